// File: rtl/reaction_timer_ctrl_pkg.sv
// Shared types and constants for the reaction-timer game controller.
// Pure declarations: no latency.
// No flow control.
package reaction_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_WAIT   = 4'd1,
        ST_GO     = 4'd2,
        ST_RESULT = 4'd3,
        ST_FALSE  = 4'd4,
        ST_TOUT   = 4'd5
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [9:0]  BEST_NONE = 10'h3FF;

endpackage

// File: rtl/reaction_timer_ctrl_if.sv
// Board-side signal bundle: raw keys in, game status out to LEDR/HEX paths.
// Wires only: no latency.
// No flow control; keys are level inputs, status is level output.
interface reaction_timer_ctrl_if;
    logic       key_start_n;
    logic       key_react_n;
    logic [3:0] state_code;
    logic       led_go;
    logic [9:0] result_ms;
    logic [9:0] best_ms;
    logic       result_valid;
    logic       false_start;
    logic       timeout;

    modport master (
        output key_start_n, key_react_n,
        input  state_code, led_go, result_ms, best_ms,
               result_valid, false_start, timeout
    );

    modport slave (
        input  key_start_n, key_react_n,
        output state_code, led_go, result_ms, best_ms,
               result_valid, false_start, timeout
    );
endinterface

// File: rtl/key_sync_edge.sv
// Synchronises an async active-low key and emits a 1-cycle pulse on its press.
// Latency: pulse is high in the 3rd cycle after the pin falls.
// No backpressure; a press while the pulse is pending is simply merged.
module key_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic pulse
);
    logic meta;
    logic sync;
    logic sync_d;

    // Keys idle high, so the chain resets to 1 and no pulse fires out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b1;
            sync   <= 1'b1;
            sync_d <= 1'b1;
            pulse  <= 1'b0;
        end else begin
            meta   <= key_n;
            sync   <= meta;
            sync_d <= sync;
            pulse  <= sync_d & ~sync;
        end
    end
endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer game FSM with 1 ms timebase, random-delay LFSR and best score.
// Latency: state/status update 4 clk after a key pin falls; ticks every TICK_DIV clk.
// No backpressure; presses that are not meaningful in the current state are dropped.
module reaction_timer_ctrl
    import reaction_pkg::*;
#(
    parameter int TICK_DIV    = 50000,
    parameter int MIN_WAIT_MS = 1000,
    parameter int RAND_BITS   = 11,
    parameter int MAX_MS      = 999
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reaction_timer_ctrl_if.slave io
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [3:0] S_IDLE   = ST_IDLE;
    localparam logic [3:0] S_WAIT   = ST_WAIT;
    localparam logic [3:0] S_GO     = ST_GO;
    localparam logic [3:0] S_RESULT = ST_RESULT;
    localparam logic [3:0] S_FALSE  = ST_FALSE;
    localparam logic [3:0] S_TOUT   = ST_TOUT;

    if (MIN_WAIT_MS + (1 << RAND_BITS) - 1 >= 4096) begin : g_wait_range
        $error("reaction_timer_ctrl: maximum wait does not fit 12 bits");
    end

    logic start_p, react_p;

    key_sync_edge u_start (.clk(clk), .rst_n(rst_n), .key_n(io.key_start_n), .pulse(start_p));
    key_sync_edge u_react (.clk(clk), .rst_n(rst_n), .key_n(io.key_react_n), .pulse(react_p));

    logic [15:0]   lfsr_q;
    logic [PW-1:0] presc_q;
    logic          tick;
    logic [3:0]    state_q, state_d;
    logic [11:0]   wait_q, wait_d;
    logic [9:0]    elapsed_q, elapsed_d;
    logic [9:0]    result_q, result_d;
    logic [9:0]    best_q;
    logic          res_entry_q;
    logic          led_go_q, result_valid_q, false_start_q, timeout_q;

    assign tick = (presc_q == PW'(TICK_DIV - 1));

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        elapsed_d = elapsed_q;
        result_d  = result_q;
        case (state_q)
            S_IDLE, S_RESULT, S_FALSE, S_TOUT: begin
                if (start_p) begin
                    state_d = S_WAIT;
                    wait_d  = 12'(MIN_WAIT_MS) + 12'(lfsr_q[RAND_BITS-1:0]);
                end
            end
            S_WAIT: begin
                if (react_p) begin
                    state_d = S_FALSE;
                end else if (tick) begin
                    if (wait_q <= 12'd1) begin
                        state_d   = S_GO;
                        elapsed_d = '0;
                    end else begin
                        wait_d = wait_q - 12'd1;
                    end
                end
            end
            S_GO: begin
                // A react coincident with a tick scores the pre-increment value.
                if (react_p) begin
                    state_d  = S_RESULT;
                    result_d = elapsed_q;
                end else if (tick) begin
                    if (elapsed_q >= 10'(MAX_MS - 1)) begin
                        state_d   = S_TOUT;
                        elapsed_d = 10'(MAX_MS);
                        result_d  = 10'(MAX_MS);
                    end else begin
                        elapsed_d = elapsed_q + 10'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q         <= LFSR_SEED;
            presc_q        <= '0;
            state_q        <= S_IDLE;
            wait_q         <= '0;
            elapsed_q      <= '0;
            result_q       <= '0;
            best_q         <= BEST_NONE;
            res_entry_q    <= 1'b0;
            led_go_q       <= 1'b0;
            result_valid_q <= 1'b0;
            false_start_q  <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            // Restarting the prescaler on entry makes the first tick land TICK_DIV clk later.
            if (state_d != state_q || tick) presc_q <= '0;
            else                            presc_q <= presc_q + PW'(1);
            state_q        <= state_d;
            wait_q         <= wait_d;
            elapsed_q      <= elapsed_d;
            result_q       <= result_d;
            res_entry_q    <= (state_d == S_RESULT) && (state_q != S_RESULT);
            if (res_entry_q && (result_q < best_q)) best_q <= result_q;
            led_go_q       <= (state_d == S_GO);
            result_valid_q <= (state_d == S_RESULT);
            false_start_q  <= (state_d == S_FALSE);
            timeout_q      <= (state_d == S_TOUT);
        end
    end

    assign io.state_code   = state_q;
    assign io.led_go       = led_go_q;
    assign io.result_ms    = result_q;
    assign io.best_ms      = best_q;
    assign io.result_valid = result_valid_q;
    assign io.false_start  = false_start_q;
    assign io.timeout      = timeout_q;
endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Randomised game rounds checked against a timing model of the game rules.
module tb_reaction_timer_ctrl;
    localparam int TD   = 4;
    localparam int MINW = 3;
    localparam int MAXM = 999;

    logic clk = 1'b0;
    logic rst_n;
    reaction_timer_ctrl_if bus();

    reaction_timer_ctrl #(.TICK_DIV(TD), .MIN_WAIT_MS(MINW), .RAND_BITS(2), .MAX_MS(MAXM)) dut (
        .clk(clk), .rst_n(rst_n), .io(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_best = 1023;
    int exp_wait;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        int taps [4] = '{16, 14, 13, 11};
        logic fb = 1'b0;
        foreach (taps[i]) fb ^= v[taps[i]-1];
        return {v[14:0], fb};
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= lfsr_next(m_lfsr);

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Press START (optionally with REACT) and expect WAIT exactly 4 clk later.
    task automatic press_start(input int old_state, input bit with_react);
        bus.key_start_n = 1'b0;
        if (with_react) bus.key_react_n = 1'b0;
        cyc(3);
        exp_wait = MINW + int'(m_lfsr[1:0]);
        chk("start_not_early", bus.state_code, old_state);
        cyc(1);
        chk("start_to_wait", bus.state_code, 1);
        bus.key_start_n = 1'b1;
        bus.key_react_n = 1'b1;
    endtask

    task automatic wait_go();
        cyc(4 * exp_wait - 1);
        chk("go_not_early", bus.led_go, 0);
        cyc(1);
        chk("go_led", bus.led_go, 1);
        chk("go_state", bus.state_code, 2);
    endtask

    // REACT pulse lands on cycle GO+4r+d; d==4 coincides with tick r+1.
    task automatic react(input int r, input int d);
        int exp_res;
        exp_res = (4 * r + d - 1) / TD;
        cyc(4 * r + d - 4);
        bus.key_react_n = 1'b0;
        cyc(3);
        chk("go_hold", bus.led_go, 1);
        cyc(1);
        bus.key_react_n = 1'b1;
        chk("result_valid", bus.result_valid, 1);
        chk("result_state", bus.state_code, 3);
        chk("result_ms", bus.result_ms, exp_res);
        chk("result_led_off", bus.led_go, 0);
        if (exp_res < m_best) m_best = exp_res;
        cyc(2);
        chk("best_ms", bus.best_ms, m_best);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        bus.key_start_n = 1'b1;
        bus.key_react_n = 1'b1;
        cyc(3);
        chk("rst_state", bus.state_code, 0);
        chk("rst_led", bus.led_go, 0);
        chk("rst_result", bus.result_ms, 0);
        chk("rst_best", bus.best_ms, 1023);
        chk("rst_flags", {bus.result_valid, bus.false_start, bus.timeout}, 0);
        rst_n = 1'b1;
        cyc(2);

        // Timeout round with a START press ignored in GO.
        press_start(0, 1'b0);
        wait_go();
        bus.key_start_n = 1'b0;
        cyc(6);
        chk("start_ignored_go", bus.state_code, 2);
        bus.key_start_n = 1'b1;
        cyc(MAXM * TD - 6 - 1);
        chk("tout_not_early", bus.timeout, 0);
        cyc(1);
        chk("tout_flag", bus.timeout, 1);
        chk("tout_state", bus.state_code, 5);
        chk("tout_result", bus.result_ms, MAXM);
        chk("tout_led", bus.led_go, 0);
        cyc(2);
        chk("tout_best", bus.best_ms, 1023);
        bus.key_react_n = 1'b0;
        cyc(6);
        chk("react_ignored_tout", bus.state_code, 5);
        bus.key_react_n = 1'b1;

        press_start(5, 1'b0);
        wait_go();
        react(5, $urandom_range(1, 4));
        press_start(3, 1'b0);
        wait_go();
        react(7, $urandom_range(1, 4));

        // False start during WAIT.
        press_start(3, 1'b0);
        k = $urandom_range(0, 7);
        cyc(k);
        bus.key_react_n = 1'b0;
        cyc(4);
        bus.key_react_n = 1'b1;
        chk("false_flag", bus.false_start, 1);
        chk("false_state", bus.state_code, 4);
        cyc(4 * 7);
        chk("false_no_go", bus.led_go, 0);
        chk("false_best", bus.best_ms, m_best);
        bus.key_react_n = 1'b0;
        cyc(6);
        chk("react_ignored_false", bus.state_code, 4);
        bus.key_react_n = 1'b1;

        press_start(4, 1'b0);
        wait_go();
        react(2, 4);

        // Both keys together: REACT wins in WAIT, START wins in FALSE.
        press_start(3, 1'b0);
        cyc(1);
        bus.key_start_n = 1'b0;
        bus.key_react_n = 1'b0;
        cyc(4);
        bus.key_start_n = 1'b1;
        bus.key_react_n = 1'b1;
        chk("both_in_wait", bus.state_code, 4);
        cyc(2);
        press_start(4, 1'b1);
        wait_go();
        react($urandom_range(1, 12), $urandom_range(1, 4));
        for (int i = 0; i < 4; i++) begin
            press_start(3, 1'b0);
            wait_go();
            react($urandom_range(1, 12), $urandom_range(1, 4));
        end

        // Reset in the middle of GO.
        press_start(3, 1'b0);
        wait_go();
        cyc($urandom_range(1, 10));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", bus.state_code, 0);
        chk("mid_rst_led", bus.led_go, 0);
        chk("mid_rst_best", bus.best_ms, 1023);
        cyc(1);
        chk("mid_rst_hold", bus.state_code, 0);
        chk("mid_rst_result", bus.result_ms, 0);
        rst_n = 1'b1;
        m_best = 1023;
        cyc(2);
        press_start(0, 1'b0);
        wait_go();
        react(3, $urandom_range(1, 4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
